// File: rtl/bist_sequencer_if.sv
// rtl/bist_sequencer_if.sv - TAP-side load/run bus and CUT stimulus/response bundle for the BIST sequencer
interface bist_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 10
);
  logic          prg_clr;
  logic          prg_we;
  logic [DW-1:0] prg_data;
  logic          chk_we;
  logic [7:0]    chk_data;
  logic          start;
  logic          abort;
  logic [7:0]    dut_in;
  logic          dut_en;
  logic [7:0]    dut_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail_valid;
  logic [AW-1:0] fail_addr;
  logic [7:0]    err_cnt;
  logic          ovf;
  logic [15:0]   status;

  modport master (
    output prg_clr, prg_we, prg_data, chk_we, chk_data, start, abort, dut_out,
    input  dut_in, dut_en, busy, done, pass, fail_valid, fail_addr, err_cnt, ovf, status
  );

  modport slave (
    input  prg_clr, prg_we, prg_data, chk_we, chk_data, start, abort, dut_out,
    output dut_in, dut_en, busy, done, pass, fail_valid, fail_addr, err_cnt, ovf, status
  );
endinterface

// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - BIST program sequencer with masked response compare and error capture
module bist_sequencer #(
  parameter int DEPTH  = 256,
  parameter int AW     = 8,
  parameter int DW     = 10,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  bist_sequencer_if.slave bus
);

  // Lengths and pointers need one extra bit so that "full" (== DEPTH) is representable.
  localparam int LW = AW + 1;
  localparam int CW = ($clog2(SETTLE) > 8) ? $clog2(SETTLE) : 8;
  localparam logic [LW-1:0] FULL        = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L       = LW'(1);
  localparam logic [CW-1:0] ONE_C       = CW'(1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

  localparam logic [1:0] OP_APPLY = 2'b00;
  localparam logic [1:0] OP_MASK  = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_APPLY,
    S_SETTLE,
    S_COMPARE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] prg_mem [DEPTH];
  logic [7:0]    chk_mem [DEPTH];

  logic [LW-1:0] prg_len, chk_len, pc, ep;
  logic [CW-1:0] cnt;
  logic [DW-1:0] word;
  logic [7:0]    exp_q, mask, dut_in_q, err_cnt_q;
  logic          dut_en_q, fail_valid_q, pass_q, aborted_q, ovf_q;
  logic [AW-1:0] fail_addr_q;

  logic [1:0] opcode;
  logic [7:0] payload;
  logic       busy, done, pass;
  logic       start_run, abort_run, mismatch, prg_wr, chk_wr;

  assign opcode  = word[DW-1:DW-2];
  assign payload = word[7:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, run-control strobes and status-facing outputs
  always_comb begin
    state_n   = state;
    busy      = (state != S_IDLE) && (state != S_FINISH);
    abort_run = bus.abort && (state != S_IDLE);
    start_run = (state == S_IDLE) && bus.start && !bus.abort;
    done      = (state == S_FINISH) && !bus.abort;
    pass      = (state == S_FINISH) ? (done && (err_cnt_q == 8'd0)) : pass_q;
    mismatch  = (ep >= chk_len) || (((bus.dut_out ^ exp_q) & mask) != 8'd0);
    prg_wr    = bus.prg_we && !bus.prg_clr && !busy && (prg_len != FULL);
    chk_wr    = bus.chk_we && !bus.prg_clr && !busy && (chk_len != FULL);

    case (state)
      S_IDLE:    if (start_run) state_n = S_FETCH;
      S_FETCH:   state_n = (pc == prg_len) ? S_FINISH : S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_APPLY: state_n = S_APPLY;
          OP_MASK:  state_n = S_FETCH;
          OP_WAIT:  state_n = (payload == 8'd0) ? S_FETCH : S_WAIT;
          OP_END:   state_n = S_FINISH;
          default:  state_n = S_FINISH;
        endcase
      end
      S_APPLY:   state_n = (SETTLE > 1) ? S_SETTLE : S_COMPARE;
      S_SETTLE:  if (cnt <= ONE_C) state_n = S_COMPARE;
      S_COMPARE: state_n = S_FETCH;
      S_WAIT:    if (cnt <= ONE_C) state_n = S_FETCH;
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase

    if (abort_run) state_n = S_IDLE;
  end

  // Buffer writes and the synchronous reads of the program word and expected value
  always_ff @(posedge clk) begin
    if (prg_wr) prg_mem[prg_len[AW-1:0]] <= bus.prg_data;
    if (chk_wr) chk_mem[chk_len[AW-1:0]] <= bus.chk_data;
    if (state == S_FETCH) word  <= prg_mem[pc[AW-1:0]];
    if (state == S_APPLY) exp_q <= chk_mem[ep[AW-1:0]];
  end

  // Buffer fill pointers and the sticky overflow flag; writes during a run are simply dropped
  always_ff @(posedge clk) begin
    if (rst || bus.prg_clr) begin
      prg_len <= '0;
      chk_len <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (prg_wr) prg_len <= prg_len + ONE_L;
      if (chk_wr) chk_len <= chk_len + ONE_L;
      if (!busy && ((bus.prg_we && (prg_len == FULL)) || (bus.chk_we && (chk_len == FULL))))
        ovf_q <= 1'b1;
    end
  end

  // Run datapath: pointers, mask, stimulus, countdown and error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      ep           <= '0;
      cnt          <= '0;
      mask         <= 8'hFF;
      dut_in_q     <= 8'd0;
      dut_en_q     <= 1'b0;
      err_cnt_q    <= 8'd0;
      fail_valid_q <= 1'b0;
      fail_addr_q  <= '0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (abort_run) begin
      dut_en_q  <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_run) begin
            pc           <= '0;
            ep           <= '0;
            err_cnt_q    <= 8'd0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            aborted_q    <= 1'b0;
            mask         <= 8'hFF;
          end
        end
        S_DECODE: begin
          if (opcode == OP_MASK) begin
            mask <= payload;
            pc   <= pc + ONE_L;
          end else if (opcode == OP_WAIT) begin
            if (payload == 8'd0) pc  <= pc + ONE_L;
            else                 cnt <= CW'(payload);
          end
        end
        S_APPLY: begin
          dut_in_q <= payload;
          dut_en_q <= 1'b1;
          cnt      <= SETTLE_LOAD;
        end
        S_SETTLE: cnt <= cnt - ONE_C;
        S_COMPARE: begin
          if (mismatch) begin
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (!fail_valid_q) begin
              fail_addr_q  <= pc[AW-1:0];
              fail_valid_q <= 1'b1;
            end
          end
          ep       <= ep + ONE_L;
          pc       <= pc + ONE_L;
          dut_en_q <= 1'b0;
        end
        S_WAIT: begin
          cnt <= cnt - ONE_C;
          if (cnt <= ONE_C) pc <= pc + ONE_L;
        end
        S_FINISH: pass_q <= (err_cnt_q == 8'd0);
        default: ;
      endcase
    end
  end

  assign bus.dut_in     = dut_in_q;
  assign bus.dut_en     = dut_en_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.ovf        = ovf_q;
  assign bus.status     = {busy, pass, fail_valid_q, aborted_q, ovf_q, 3'b000, err_cnt_q};

endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - self-checking bench for bist_sequencer against a cost-table run model
module tb_bist_sequencer;
  localparam int DEPTH  = 512;
  localparam int AW     = 9;
  localparam int SETTLE = 2;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en;
    logic [7:0] din;
    logic       chk_st;
    logic [15:0] st;
    logic [8:0] fa;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] corrupt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t trace[$];
  int   pop_idx;
  int   done_at;
  int   prog_a[$];
  int   expv_a[$];
  int   m_plen, m_elen, m_cyc, m_lim;
  logic m_ovf;
  exp_t e;

  bist_sequencer_if #(.AW(AW), .DW(10)) bus ();

  bist_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(10), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.dut_out = bus.dut_in ^ corrupt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic en, input logic [7:0] din,
                              input logic cs, input logic [15:0] st, input logic [8:0] fa);
    exp_t r;
    r.busy = b; r.done = d; r.en = en; r.din = din; r.chk_st = cs; r.st = st; r.fa = fa;
    return r;
  endfunction

  // Compare process: every cycle of a run is checked against the model trace
  always @(negedge clk) begin
    if (trace.size() > 0) begin
      e = trace.pop_front();
      check($sformatf("busy@%0d", pop_idx), 32'(bus.busy), 32'(e.busy));
      check($sformatf("done@%0d", pop_idx), 32'(bus.done), 32'(e.done));
      check($sformatf("dut_en@%0d", pop_idx), 32'(bus.dut_en), 32'(e.en));
      if (e.en) check($sformatf("dut_in@%0d", pop_idx), 32'(bus.dut_in), 32'(e.din));
      if (e.chk_st) begin
        check($sformatf("status@%0d", pop_idx), 32'(bus.status), 32'(e.st));
        if (e.st[13]) check($sformatf("fail_addr@%0d", pop_idx), 32'(bus.fail_addr), 32'(e.fa));
      end
      if (bus.done) done_at = pop_idx;
      pop_idx++;
    end
  end

  task automatic add(input int n, input logic en, input logic [7:0] din);
    for (int i = 0; i < n; i++) begin
      if (m_cyc <= m_lim) trace.push_back(mk(1'b1, 1'b0, en, din, 1'b0, 16'h0, 9'h0));
      m_cyc++;
    end
  endtask

  // Model: expand the program by per-instruction cycle cost and apply the compare rules
  task automatic build(input int abort_at);
    int pc, ep, err, fa, cmp_c;
    logic fv, miss;
    logic [7:0] mask, pl;
    logic [9:0] w;
    logic [15:0] st;
    bit stop;
    pc = 0; ep = 0; err = 0; fa = 0; fv = 1'b0; mask = 8'hFF; stop = 1'b0;
    m_lim = (abort_at > 0) ? abort_at : 32'h7fffffff;
    trace.push_back(mk(1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 16'h0, 9'h0));
    m_cyc = 1;
    while (!stop) begin
      if (pc == m_plen) begin
        add(1, 1'b0, 8'h0);
        stop = 1'b1;
      end else begin
        w  = 10'(prog_a[pc]);
        pl = w[7:0];
        case (w[9:8])
          2'b00: begin
            add(3, 1'b0, 8'h0);
            add(SETTLE - 1, 1'b1, pl);
            cmp_c = m_cyc;
            add(1, 1'b1, pl);
            if (cmp_c < m_lim) begin
              if (ep >= m_elen) miss = 1'b1;
              else miss = (((pl ^ corrupt) ^ 8'(expv_a[ep])) & mask) != 8'h0;
              if (miss) begin
                if (err < 255) err++;
                if (!fv) begin fv = 1'b1; fa = pc; end
              end
            end
            ep++; pc++;
          end
          2'b01: begin add(2, 1'b0, 8'h0); mask = pl; pc++; end
          2'b10: begin add(2 + int'(pl), 1'b0, 8'h0); pc++; end
          default: begin add(2, 1'b0, 8'h0); stop = 1'b1; end
        endcase
      end
    end
    if (abort_at > 0 && abort_at < m_cyc) begin
      st = {1'b0, 1'b0, fv, 1'b1, m_ovf, 3'b000, 8'(err)};
      trace.push_back(mk(1'b0, 1'b0, 1'b0, 8'h0, 1'b1, st, 9'(fa)));
      trace.push_back(mk(1'b0, 1'b0, 1'b0, 8'h0, 1'b1, st, 9'(fa)));
    end else begin
      st = {1'b0, (err == 0), fv, 1'b0, m_ovf, 3'b000, 8'(err)};
      trace.push_back(mk(1'b0, 1'b1, 1'b0, 8'h0, 1'b1, st, 9'(fa)));
      trace.push_back(mk(1'b0, 1'b0, 1'b0, 8'h0, 1'b1, st, 9'(fa)));
    end
  endtask

  task automatic load();
    int n;
    n = (prog_a.size() > expv_a.size()) ? prog_a.size() : expv_a.size();
    bus.prg_clr = 1'b1;
    @(posedge clk); #1;
    bus.prg_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.prg_we = 1'b0;
      bus.chk_we = 1'b0;
      if (i < prog_a.size()) begin bus.prg_we = 1'b1; bus.prg_data = 10'(prog_a[i]); end
      if (i < expv_a.size()) begin bus.chk_we = 1'b1; bus.chk_data = 8'(expv_a[i]); end
      @(posedge clk); #1;
    end
    bus.prg_we = 1'b0;
    bus.chk_we = 1'b0;
    m_plen = (prog_a.size() > DEPTH) ? DEPTH : prog_a.size();
    m_elen = (expv_a.size() > DEPTH) ? DEPTH : expv_a.size();
    m_ovf  = (prog_a.size() > DEPTH) || (expv_a.size() > DEPTH);
  endtask

  task automatic run(input int abort_at, input bit poke);
    int bound;
    build(abort_at);
    bound = trace.size() + 8;
    pop_idx = 0;
    done_at = -1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < bound && trace.size() > 0; c++) begin
      bus.abort    = (c == abort_at);
      bus.prg_we   = poke && (c == 2);
      bus.prg_data = 10'h300;
      @(posedge clk); #1;
    end
    bus.abort  = 1'b0;
    bus.prg_we = 1'b0;
    check("trace_drained", 32'(trace.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; corrupt = 8'h00;
    bus.prg_clr = 1'b0; bus.prg_we = 1'b0; bus.prg_data = '0;
    bus.chk_we = 1'b0; bus.chk_data = '0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_status", 32'(bus.status), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_dut_en", 32'(bus.dut_en), 32'h0);
    check("rst_dut_in", 32'(bus.dut_in), 32'h0);
    check("rst_fail_addr", 32'(bus.fail_addr), 32'h0);

    prog_a = '{32'h002, 32'h0B1, 32'h300}; expv_a = '{32'h02, 32'hB1};
    load(); run(0, 1'b0);
    check("normal_done_at", 32'(done_at), 32'd13);
    check("normal_status", 32'(bus.status), 32'h4000);

    prog_a = '{32'h10F, 32'h0F5}; expv_a = '{32'h05};
    load(); run(0, 1'b0);
    check("mask0f_status", 32'(bus.status), 32'h4000);

    prog_a = '{32'h1F0, 32'h0F5};
    load(); run(0, 1'b0);
    check("maskf0_done_at", 32'(done_at), 32'd9);
    check("maskf0_status", 32'(bus.status), 32'h2001);
    check("maskf0_fail_addr", 32'(bus.fail_addr), 32'd1);

    prog_a = '{32'h001, 32'h002, 32'h003}; expv_a = '{32'h01, 32'h02};
    load(); run(0, 1'b0);
    check("missing_status", 32'(bus.status), 32'h2001);
    check("missing_fail_addr", 32'(bus.fail_addr), 32'd2);

    prog_a = '{32'h002, 32'h0B1, 32'h300}; expv_a = '{32'h02, 32'hB1};
    load(); run(9, 1'b0);
    check("abort_no_done", 32'(done_at), 32'hFFFFFFFF);
    check("abort_status", 32'(bus.status), 32'h1000);
    check("abort_dut_en", 32'(bus.dut_en), 32'h0);
    run(0, 1'b0);
    check("rerun_done_at", 32'(done_at), 32'd13);
    check("rerun_status", 32'(bus.status), 32'h4000);

    prog_a.delete(); expv_a.delete();
    load(); run(0, 1'b0);
    check("empty_done_at", 32'(done_at), 32'd2);
    check("empty_status", 32'(bus.status), 32'h4000);

    prog_a = '{32'h200, 32'h203, 32'h300};
    load(); run(0, 1'b0);
    check("wait_done_at", 32'(done_at), 32'd10);

    prog_a = '{32'h011}; expv_a = '{32'h11};
    load(); run(0, 1'b1);
    check("busy_we_done_at", 32'(done_at), 32'd7);
    run(0, 1'b0);
    check("busy_we_rerun_done_at", 32'(done_at), 32'd7);
    check("busy_we_ovf", 32'(bus.ovf), 32'h0);

    prog_a.delete(); expv_a.delete();
    for (int i = 0; i < DEPTH + 1; i++) prog_a.push_back(32'h200);
    load();
    check("ovf_flag", 32'(bus.ovf), 32'h1);
    run(0, 1'b0);
    check("ovf_done_at", 32'(done_at), 32'd1026);
    check("ovf_status", 32'(bus.status), 32'h4800);

    prog_a.delete(); expv_a.delete();
    for (int i = 0; i < 300; i++) begin
      prog_a.push_back(i & 8'hFF);
      expv_a.push_back(~i & 8'hFF);
    end
    load(); run(0, 1'b0);
    check("sat_status", 32'(bus.status), 32'h20FF);
    check("sat_err_cnt", 32'(bus.err_cnt), 32'd255);
    check("sat_fail_addr", 32'(bus.fail_addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
